// File: rtl/freelist_pkg.sv
// Purpose: shared constants for the physical register free list.
// Latency: n/a (constants only).
// Backpressure: n/a.
`include "sys_defs.svh"

package freelist_pkg;

  // PR 0 is the hardwired zero register: never granted, never freed.
  localparam int unsigned FL_ZERO_PR = 0;

endpackage

// File: rtl/freelist_psel.sv
// Purpose: N-way lowest-bit priority selector; output k is the k-th lowest set bit.
// Latency: combinational.
// Backpressure: none; sel_vld[k]=0 when fewer than k+1 bits are set.
//
// Ports: bitmap (candidates), sel_vld[k] (k-th pick exists), sel_idx[k] (its index).
`include "sys_defs.svh"

module freelist_psel
  import freelist_pkg::*;
#(
  parameter int N     = `N,
  parameter int W     = `PHYS_REG_SZ_R10K,
  parameter int TAG_W = `PHYS_TAG
) (
  input  logic [W-1:0]            bitmap,
  output logic [N-1:0]            sel_vld,
  output logic [N-1:0][TAG_W-1:0] sel_idx
);

  logic [W-1:0] rem;
  logic         found;

  // Each pass takes the lowest remaining bit and removes it, so the
  // picks are distinct and ascending.
  always_comb begin
    rem     = bitmap;
    found   = 1'b0;
    sel_vld = '0;
    sel_idx = '0;
    for (int k = 0; k < N; k++) begin
      found = 1'b0;
      for (int i = 0; i < W; i++) begin
        if (!found && rem[i]) begin
          found      = 1'b1;
          sel_vld[k] = 1'b1;
          sel_idx[k] = TAG_W'(i);
          rem[i]     = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sys_defs.svh
// Shared system-wide sizing macros for the rename/retire datapath.
// N: rename/retire width, PHYS_REG_SZ_R10K: physical register count,
// ARCH_REG_SZ: architectural register count, PHYS_TAG: physical tag width.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define N                3
`define PHYS_REG_SZ_R10K 64
`define ARCH_REG_SZ      32
`define PHYS_TAG         $clog2(`PHYS_REG_SZ_R10K)

`endif

// File: rtl/freelist.sv
// Purpose: physical register free list with committed-state (arch_used) tracking.
// Latency: grants/tags combinational in the request cycle; bitmap updates at next edge.
// Backpressure: lanes beyond the free count (or any lane during mispredict/reset) see alloc_gnt=0.
//
// Ports: alloc_req/alloc_gnt/alloc_tags (dispatch allocation), free_avail (saturated,
// registered-bitmap count), free_mask (retire release), commit_en/commit_tags (retire
// commit), mispredict (flush: rebuild free list from arch_used), fl_err (sticky error).
// Optional macro FREELIST_CHECK_EN: enables double-free / commit-of-free detection on fl_err.
`include "sys_defs.svh"

module freelist
  import freelist_pkg::*;
#(
  parameter  int N          = `N,
  parameter  int PHYS_REGS  = `PHYS_REG_SZ_R10K,
  parameter  int ARCH_COUNT = `ARCH_REG_SZ,
  localparam int TAG_W      = `PHYS_TAG,
  localparam int AVAIL_W    = $clog2(N + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0]            alloc_req,
  output logic [N-1:0]            alloc_gnt,
  output logic [N-1:0][TAG_W-1:0] alloc_tags,
  output logic [AVAIL_W-1:0]      free_avail,
  input  logic [PHYS_REGS-1:0]    free_mask,
  input  logic [N-1:0]            commit_en,
  input  logic [N-1:0][TAG_W-1:0] commit_tags,
  input  logic                    mispredict,
  output logic                    fl_err
);

  localparam logic [PHYS_REGS-1:0] ZERO_MASK = PHYS_REGS'(1) << FL_ZERO_PR;
  localparam logic [PHYS_REGS-1:0] ARCH_RST  =
    {{(PHYS_REGS - ARCH_COUNT){1'b0}}, {ARCH_COUNT{1'b1}}};
  localparam logic [PHYS_REGS-1:0] FREE_RST  = ~ARCH_RST & ~ZERO_MASK;

  logic [PHYS_REGS-1:0]     free_q, free_next;
  logic [PHYS_REGS-1:0]     arch_q, arch_next;
  logic [PHYS_REGS-1:0]     rel_mask, alloc_clr, commit_set;
  logic [N-1:0]             sel_vld;
  logic [N-1:0][TAG_W-1:0]  sel_idx;
  int unsigned              rank;
  int unsigned              free_cnt;

  // Only PRs already free in the register are candidates; PRs released this
  // cycle become grantable next cycle.
  freelist_psel #(
    .N     (N),
    .W     (PHYS_REGS),
    .TAG_W (TAG_W)
  ) u_psel (
    .bitmap  (free_q & ~ZERO_MASK),
    .sel_vld (sel_vld),
    .sel_idx (sel_idx)
  );

  // Requesting lanes consume picks in lane order; a lane's rank is the number
  // of older requesting lanes. Picks are dense, so a failed lane ends granting.
  always_comb begin
    alloc_gnt  = '0;
    alloc_tags = '0;
    rank       = 0;
    for (int w = 0; w < N; w++) begin
      if (reset && !mispredict && alloc_req[w] && (rank < N)) begin
        if (sel_vld[rank]) begin
          alloc_gnt[w]  = 1'b1;
          alloc_tags[w] = sel_idx[rank];
          rank          = rank + 1;
        end
      end
    end
  end

  always_comb begin
    alloc_clr  = '0;
    commit_set = '0;
    for (int w = 0; w < N; w++) begin
      if (alloc_gnt[w]) alloc_clr[alloc_tags[w]] = 1'b1;
      if (commit_en[w]) commit_set[commit_tags[w]] = 1'b1;
    end
  end

  assign rel_mask  = free_mask & ~ZERO_MASK;
  // A commit in the same cycle as a release of that PR leaves it architectural.
  assign arch_next = (arch_q & ~rel_mask) | commit_set;

  // On a flush everything not holding committed state is free again.
  always_comb begin
    if (mispredict) free_next = ~arch_next;
    else            free_next = (free_q & ~alloc_clr) | rel_mask;
    free_next = free_next & ~ZERO_MASK;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_q <= FREE_RST;
      arch_q <= ARCH_RST;
    end else begin
      free_q <= free_next;
      arch_q <= arch_next;
    end
  end

  // Count is taken from the registered bitmap, so it lags grants by a cycle.
  always_comb begin
    free_cnt = 0;
    for (int i = 0; i < PHYS_REGS; i++) free_cnt = free_cnt + 32'(free_q[i]);
    if (free_cnt >= N) free_avail = AVAIL_W'(N);
    else               free_avail = AVAIL_W'(free_cnt);
  end

`ifdef FREELIST_CHECK_EN
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = |(rel_mask & free_q);
    for (int w = 0; w < N; w++) begin
      if (commit_en[w] && free_q[commit_tags[w]]) err_set = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign fl_err = err_q;
`else
  assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist.sv
// Purpose: directed self-checking bench for freelist (N=3, 64 PRs, 32 arch regs).
// Latency: inputs driven on falling edge, combinational outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_freelist;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      alloc_req;
  logic [2:0]      alloc_gnt;
  logic [2:0][5:0] alloc_tags;
  logic [1:0]      free_avail;
  logic [63:0]     free_mask;
  logic [2:0]      commit_en;
  logic [2:0][5:0] commit_tags;
  logic            mispredict;
  logic            fl_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freelist #(
    .N          (3),
    .PHYS_REGS  (64),
    .ARCH_COUNT (32)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_tags  (alloc_tags),
    .free_avail  (free_avail),
    .free_mask   (free_mask),
    .commit_en   (commit_en),
    .commit_tags (commit_tags),
    .mispredict  (mispredict),
    .fl_err      (fl_err)
  );

  task automatic idle_inputs();
    alloc_req   = '0;
    free_mask   = '0;
    commit_en   = '0;
    commit_tags = '0;
    mispredict  = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    alloc_req = 3'b111;
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (alloc_gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt got %b want 000", alloc_gnt); end
    checks++; if (alloc_tags !== 18'd0) begin errors++; $display("FAIL rst_tags got %h want 0", alloc_tags); end
    checks++; if (free_avail !== 2'd3) begin errors++; $display("FAIL rst_avail got %0d want 3", free_avail); end
    checks++; if (fl_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", fl_err); end
    @(negedge clk);
  endtask

  task automatic test_basic_alloc();
    do_reset();
    alloc_req = 3'b111; #1;
    checks++; if (alloc_gnt !== 3'b111) begin errors++; $display("FAIL basic_gnt got %b want 111", alloc_gnt); end
    checks++; if (alloc_tags[0] !== 6'd32 || alloc_tags[1] !== 6'd33 || alloc_tags[2] !== 6'd34) begin
      errors++; $display("FAIL basic_tags got %0d,%0d,%0d want 32,33,34", alloc_tags[0], alloc_tags[1], alloc_tags[2]);
    end
    @(negedge clk);
    alloc_req = 3'b001; #1;
    checks++; if (alloc_gnt !== 3'b001 || alloc_tags[0] !== 6'd35) begin
      errors++; $display("FAIL basic_next got gnt=%b tag=%0d want 001/35", alloc_gnt, alloc_tags[0]);
    end
    @(negedge clk);
    alloc_req = 3'b101; #1;
    checks++; if (alloc_gnt !== 3'b101) begin errors++; $display("FAIL sparse_gnt got %b want 101", alloc_gnt); end
    checks++; if (alloc_tags[0] !== 6'd36 || alloc_tags[1] !== 6'd0 || alloc_tags[2] !== 6'd37) begin
      errors++; $display("FAIL sparse_tags got %0d,%0d,%0d want 36,0,37", alloc_tags[0], alloc_tags[1], alloc_tags[2]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Ends with the list empty.
  task automatic test_exhaust();
    do_reset();
    alloc_req = 3'b111;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (free_avail !== 2'd2) begin errors++; $display("FAIL exh_avail2 got %0d want 2", free_avail); end
    checks++; if (alloc_gnt !== 3'b011) begin errors++; $display("FAIL exh_gnt got %b want 011", alloc_gnt); end
    checks++; if (alloc_tags[0] !== 6'd62 || alloc_tags[1] !== 6'd63 || alloc_tags[2] !== 6'd0) begin
      errors++; $display("FAIL exh_tags got %0d,%0d,%0d want 62,63,0", alloc_tags[0], alloc_tags[1], alloc_tags[2]);
    end
    @(negedge clk); #1;
    checks++; if (free_avail !== 2'd0) begin errors++; $display("FAIL exh_avail0 got %0d want 0", free_avail); end
    checks++; if (alloc_gnt !== 3'b000) begin errors++; $display("FAIL exh_empty_gnt got %b want 000", alloc_gnt); end
    @(negedge clk);
  endtask

  // Starts from the empty list left by test_exhaust.
  task automatic test_free_same_cycle();
    idle_inputs();
    alloc_req = 3'b001;
    free_mask = 64'd1 << 5;
    #1;
    checks++; if (alloc_gnt !== 3'b000) begin errors++; $display("FAIL relsame_gnt got %b want 000", alloc_gnt); end
    @(negedge clk);
    free_mask = '0; #1;
    checks++; if (free_avail !== 2'd1) begin errors++; $display("FAIL rel_avail got %0d want 1", free_avail); end
    checks++; if (alloc_gnt !== 3'b001 || alloc_tags[0] !== 6'd5) begin
      errors++; $display("FAIL rel_tag got gnt=%b tag=%0d want 001/5", alloc_gnt, alloc_tags[0]);
    end
    @(negedge clk);
    alloc_req = '0;
    free_mask = 64'd1;
    @(negedge clk);
    free_mask = '0;
    alloc_req = 3'b001; #1;
    checks++; if (free_avail !== 2'd0) begin errors++; $display("FAIL pr0_avail got %0d want 0", free_avail); end
    checks++; if (alloc_gnt !== 3'b000) begin errors++; $display("FAIL pr0_gnt got %b want 000", alloc_gnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_req = 3'b111;
    @(negedge clk);
    mispredict = 1'b1; #1;
    checks++; if (alloc_gnt !== 3'b000) begin errors++; $display("FAIL mp_gnt got %b want 000", alloc_gnt); end
    @(negedge clk);
    mispredict = 1'b0;
    alloc_req = 3'b001; #1;
    checks++; if (free_avail !== 2'd3) begin errors++; $display("FAIL mp_avail got %0d want 3", free_avail); end
    checks++; if (alloc_gnt !== 3'b001 || alloc_tags[0] !== 6'd32) begin
      errors++; $display("FAIL mp_tag got gnt=%b tag=%0d want 001/32", alloc_gnt, alloc_tags[0]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mispredict_commit();
    do_reset();
    mispredict     = 1'b1;
    commit_en      = 3'b001;
    commit_tags[0] = 6'd40;
    free_mask      = 64'd1 << 7;
    @(negedge clk);
    idle_inputs();
    alloc_req = 3'b111; #1;
    checks++; if (alloc_tags[0] !== 6'd7 || alloc_tags[1] !== 6'd32 || alloc_tags[2] !== 6'd33) begin
      errors++; $display("FAIL mpc_tags got %0d,%0d,%0d want 7,32,33", alloc_tags[0], alloc_tags[1], alloc_tags[2]);
    end
    // 34..39 go in the next two cycles; PR 40 must be skipped after that.
    repeat (3) @(negedge clk);
    #1;
    checks++; if (alloc_tags[0] !== 6'd41 || alloc_tags[1] !== 6'd42) begin
      errors++; $display("FAIL mpc_skip40 got %0d,%0d want 41,42", alloc_tags[0], alloc_tags[1]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_midop_reset();
    do_reset();
    alloc_req = 3'b111;
    repeat (11) @(negedge clk);
    #1;
    checks++; if (free_avail !== 2'd0) begin errors++; $display("FAIL mid_drained got %0d want 0", free_avail); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (free_avail !== 2'd3 || alloc_gnt !== 3'b000 || alloc_tags !== 18'd0) begin
      errors++; $display("FAIL mid_rst got avail=%0d gnt=%b tags=%h want 3/000/0", free_avail, alloc_gnt, alloc_tags);
    end
    @(negedge clk);
    reset = 1'b1;
    alloc_req = 3'b001; #1;
    checks++; if (alloc_gnt !== 3'b001 || alloc_tags[0] !== 6'd32) begin
      errors++; $display("FAIL mid_after got gnt=%b tag=%0d want 001/32", alloc_gnt, alloc_tags[0]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_err();
    do_reset();
    free_mask = 64'd1 << 50; #1;
    checks++; if (fl_err !== 1'b0) begin errors++; $display("FAIL err_pre got %b want 0", fl_err); end
    @(negedge clk);
    idle_inputs(); #1;
`ifdef FREELIST_CHECK_EN
    checks++; if (fl_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", fl_err); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (fl_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", fl_err); end
    reset = 1'b0; #1;
    checks++; if (fl_err !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", fl_err); end
    @(negedge clk);
    reset = 1'b1;
`else
    checks++; if (fl_err !== 1'b0) begin errors++; $display("FAIL err_tied got %b want 0", fl_err); end
`endif
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_basic_alloc();
    test_exhaust();
    test_free_same_cycle();
    test_mispredict();
    test_mispredict_commit();
    test_midop_reset();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freelist.md
FREELIST -- requirements
Module: freelist

Interface
REQ-001 SHALL have parameter N, default `N, meaning rename/retire width (lanes per cycle).
REQ-002 SHALL have parameter PHYS_REGS, default `PHYS_REG_SZ_R10K, meaning physical register count.
REQ-003 SHALL have parameter ARCH_COUNT, default `ARCH_REG_SZ, meaning architectural register count.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port alloc_req  input  N  dispatch lane w requests one PR; lane 0 is oldest.
REQ-007 SHALL have port alloc_gnt  output  N  lane w is granted a PR this cycle.
REQ-008 SHALL have port alloc_tags  output  N x PHYS_TAG  PR granted to lane w; 0 when not granted.
REQ-009 SHALL have port free_avail  output  $clog2(N+1)  free PR count saturated at N.
REQ-010 SHALL have port free_mask  input  PHYS_REGS  retire-stage bitmap of PRs to release.
REQ-011 SHALL have port commit_en  input  N  retire lane w commits a mapping.
REQ-012 SHALL have port commit_tags  input  N x PHYS_TAG  PR newly made architectural by lane w.
REQ-013 SHALL have port mispredict  input  1  retire-stage flush pulse.
REQ-014 SHALL have port fl_err  output  1  sticky consistency-error flag.

Function
REQ-015 SHALL hold a free bitmap (1 = free) and an arch_used bitmap (1 = holds committed state).
REQ-016 SHALL grant requesting lanes in lane order the lowest-numbered free PRs, distinct per lane, with tags valid combinationally in the request cycle.
REQ-017 SHALL, when requests exceed free PRs, grant only the lowest-numbered requesting lanes up to the free count; non-granted lanes get alloc_gnt=0.
REQ-018 SHALL clear the free bit of every granted PR at the next edge.
REQ-019 SHALL set the free bit and clear the arch_used bit of every free_mask PR at the next edge; such PRs are not grantable in the same cycle.
REQ-020 SHALL set the arch_used bit of commit_tags[w] for each commit_en[w] at the next edge.
REQ-021 SHALL never grant or free PR 0; free_mask[0] is ignored.
REQ-022 SHALL, on mispredict, load free = ~arch_used_next (arch_used including this cycle's commit and free_mask updates) with bit 0 forced to 0, and drive alloc_gnt=0 that cycle.
REQ-023 SHALL compute free_avail from the registered free bitmap only (one-cycle-stale by design).

Reset
REQ-024 SHALL, while reset is low: free bits ARCH_COUNT..PHYS_REGS-1 = 1, others 0; arch_used bits 0..ARCH_COUNT-1 = 1, others 0; fl_err=0.
REQ-025 SHALL drive alloc_gnt=0, alloc_tags=0 while reset is low; free_avail reflects the reset bitmap.
REQ-026 SHALL abandon all in-flight updates when reset asserts mid-operation.

Configuration
REQ-027 SHALL, with FREELIST_CHECK_EN defined, set fl_err on freeing an already-free PR or committing a PR that is currently free; sticky until reset.
REQ-028 SHALL, without FREELIST_CHECK_EN, tie fl_err to 0 and synthesize no check logic.

Structure
REQ-029 SHALL take PHYS_TAG, `N, `PHYS_REG_SZ_R10K, `ARCH_REG_SZ from sys_defs.svh; no new package types.
REQ-030 SHALL instantiate sub-module freelist_psel (N-way lowest-bit priority selector over a bitmap).

Verification (N=3, PHYS_REGS=64, ARCH_COUNT=32)
REQ-031 Reset, alloc_req=111 -> gnt=111, tags 32,33,34; next cycle lowest grant 35.
REQ-032 Drain to two free (62,63), alloc_req=111 -> gnt=011, tags 62,63,0; next cycle free_avail=0.
REQ-033 Empty list, free_mask bit 5 with alloc_req=001 -> gnt=000; next cycle alloc_req=001 -> tag 5.
REQ-034 Allocate 32..34, no commits, mispredict -> gnt=000; next cycle free_avail=3, alloc gives 32.
REQ-035 Same cycle: mispredict, commit_en=001 tag 40, free_mask bit 7 -> next cycle 40 not free, 7 free.
REQ-036 FREELIST_CHECK_EN: free_mask bit 50 while 50 free -> fl_err=1 next cycle, stays 1 until reset.
